// File: rtl/mem_resp_pkg.sv
// Shared FSM encoding, wait-counter width and RAM index helper for mem_responder.
// Optional parity storage is enabled by defining MEM_RESP_PARITY_EN.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WS_CNT_W  = 4;
  localparam int DEF_DEPTH = 256;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_DEPTH);

endpackage

// File: rtl/mem_responder_if.sv
// Arbiter <-> responder memory port; par_inject/parity_err exist only with MEM_RESP_PARITY_EN.
// Handshake: a request is a single-cycle-or-held level on mem_read xor mem_write, sampled only
// while mem_busy is low; completion is the one-cycle mem_ready pulse with mem_rdata valid for reads.
interface mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  import mem_resp_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_busy;
  logic              req_err;
  state_t            fsm_state;
`ifdef MEM_RESP_PARITY_EN
  logic              par_inject;
  logic              parity_err;
`endif

  modport master (
`ifdef MEM_RESP_PARITY_EN
    output par_inject,
    input  parity_err,
`endif
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata, mem_ready, mem_busy, req_err, fsm_state
  );

  modport slave (
`ifdef MEM_RESP_PARITY_EN
    input  par_inject,
    output parity_err,
`endif
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata, mem_ready, mem_busy, req_err, fsm_state
  );

endinterface

// File: rtl/mem_resp_ram.sv
// Byte-wide RAM: synchronous write, combinational read sampled by the owner on commit.
// With MEM_RESP_PARITY_EN each word carries an even-parity bit and reports a mismatch on read.
module mem_resp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_RESP_PARITY_EN
  input  logic              par_inject,
  output logic              par_bad,
`endif
  output logic [DATA_W-1:0] rdata
);

`ifdef MEM_RESP_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] word;

  always_ff @(posedge clk) begin
    if (we) begin
`ifdef MEM_RESP_PARITY_EN
      mem[addr] <= {(^wdata) ^ par_inject, wdata};
`else
      mem[addr] <= wdata;
`endif
    end
  end

  assign word  = mem[addr];
  assign rdata = word[DATA_W-1:0];
`ifdef MEM_RESP_PARITY_EN
  assign par_bad = word[DATA_W] ^ (^word[DATA_W-1:0]);
`endif

endmodule

// File: rtl/mem_responder.sv
// Memory responder: IDLE -> WAIT -> DONE FSM with programmable wait states over mem_resp_ram.
// Define MEM_RESP_PARITY_EN to add the per-word parity bit and the parity_err pulse.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);

  localparam int                  IDX_W   = idx_width(DEPTH);
  localparam logic [WS_CNT_W-1:0] WS_INIT = WS_CNT_W'(WAIT_STATES);
  localparam logic [WS_CNT_W-1:0] WS_ONE  = WS_CNT_W'(1);

  state_t              state;
  logic [WS_CNT_W-1:0] cnt;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                lat_write;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q, busy_q, req_err_q;

  logic                req_one, enter_done, c_write, ram_we;
  logic [ADDR_W-1:0]   c_addr;
  logic [DATA_W-1:0]   c_wdata, ram_rdata;
`ifdef MEM_RESP_PARITY_EN
  logic                lat_inj, c_inj, ram_par_bad, perr_q;
`endif

  // With zero wait states the access commits straight from IDLE, so the live inputs feed the RAM.
  always_comb begin
    req_one = bus.mem_read ^ bus.mem_write;
    if (state == S_IDLE) begin
      c_addr  = bus.mem_addr;
      c_wdata = bus.mem_wdata;
      c_write = bus.mem_write;
    end else begin
      c_addr  = lat_addr;
      c_wdata = lat_wdata;
      c_write = lat_write;
    end
`ifdef MEM_RESP_PARITY_EN
    c_inj = (state == S_IDLE) ? bus.par_inject : lat_inj;
`endif
    enter_done = ((state == S_IDLE) && req_one && (WAIT_STATES == 0)) ||
                 ((state == S_WAIT) && (cnt == WS_ONE));
    ram_we = enter_done && c_write && reset;
  end

  mem_resp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk        (clk),
    .we         (ram_we),
    .addr       (c_addr[IDX_W-1:0]),
    .wdata      (c_wdata),
`ifdef MEM_RESP_PARITY_EN
    .par_inject (c_inj),
    .par_bad    (ram_par_bad),
`endif
    .rdata      (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      req_err_q <= 1'b0;
`ifdef MEM_RESP_PARITY_EN
      lat_inj   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      ready_q   <= 1'b0;
      req_err_q <= 1'b0;
`ifdef MEM_RESP_PARITY_EN
      perr_q    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (bus.mem_read && bus.mem_write) begin
            req_err_q <= 1'b1;
          end else if (req_one) begin
            lat_addr  <= bus.mem_addr;
            lat_wdata <= bus.mem_wdata;
            lat_write <= bus.mem_write;
`ifdef MEM_RESP_PARITY_EN
            lat_inj   <= bus.par_inject;
`endif
            cnt    <= WS_INIT;
            busy_q <= 1'b1;
            if (WAIT_STATES == 0) begin
              state   <= S_DONE;
              ready_q <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - WS_ONE;
          if (cnt == WS_ONE) begin
            state   <= S_DONE;
            ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
      if (enter_done && !c_write) begin
        rdata_q <= ram_rdata;
`ifdef MEM_RESP_PARITY_EN
        perr_q  <= ram_par_bad;
`endif
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_busy  = busy_q;
  assign bus.req_err   = req_err_q;
  assign bus.fsm_state = state;
`ifdef MEM_RESP_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 1 and 3 wait states; the last with a 64-word RAM
// to exercise address wrap). Parity checks are compiled in with MEM_RESP_PARITY_EN.
module tb_mem_responder;
  import mem_resp_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a[3], wdat[3];
  logic       rd[3], wr[3], inj_d[3];
  logic [7:0] rdata_o[3];
  logic       ready_o[3], busy_o[3], rerr_o[3], perr_o[3];
  state_t     state_o[3];

  int ws_of[3] = '{0, 1, 3};

  mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
  mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();
  mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();

  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_STATES(3))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus0.mem_addr = a[0];  assign bus0.mem_wdata = wdat[0];
  assign bus0.mem_read = rd[0]; assign bus0.mem_write = wr[0];
  assign bus1.mem_addr = a[1];  assign bus1.mem_wdata = wdat[1];
  assign bus1.mem_read = rd[1]; assign bus1.mem_write = wr[1];
  assign bus2.mem_addr = a[2];  assign bus2.mem_wdata = wdat[2];
  assign bus2.mem_read = rd[2]; assign bus2.mem_write = wr[2];

  assign rdata_o[0] = bus0.mem_rdata; assign ready_o[0] = bus0.mem_ready;
  assign busy_o[0]  = bus0.mem_busy;  assign rerr_o[0]  = bus0.req_err;
  assign rdata_o[1] = bus1.mem_rdata; assign ready_o[1] = bus1.mem_ready;
  assign busy_o[1]  = bus1.mem_busy;  assign rerr_o[1]  = bus1.req_err;
  assign rdata_o[2] = bus2.mem_rdata; assign ready_o[2] = bus2.mem_ready;
  assign busy_o[2]  = bus2.mem_busy;  assign rerr_o[2]  = bus2.req_err;
  assign state_o[0] = bus0.fsm_state;
  assign state_o[1] = bus1.fsm_state;
  assign state_o[2] = bus2.fsm_state;

`ifdef MEM_RESP_PARITY_EN
  assign bus0.par_inject = inj_d[0];
  assign bus1.par_inject = inj_d[1];
  assign bus2.par_inject = inj_d[2];
  assign perr_o[0] = bus0.parity_err;
  assign perr_o[1] = bus1.parity_err;
  assign perr_o[2] = bus2.parity_err;
`else
  assign perr_o[0] = 1'b0;
  assign perr_o[1] = 1'b0;
  assign perr_o[2] = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] held[3];

  typedef struct {
    int         d;
    bit         w;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the ready pulse.
  task automatic access(input int d, input bit w, input logic [7:0] ad, input logic [7:0] wd,
                        input bit inj, input logic [7:0] exp_rd, input bit exp_perr);
    int k;
    bit seen;
    logic [7:0] e;
    a[d] = ad; wdat[d] = wd; rd[d] = !w; wr[d] = w; inj_d[d] = inj;
    exp_q.push_back(exp_rd);
    @(posedge clk);
    @(negedge clk);
    rd[d] = 1'b0; wr[d] = 1'b0; inj_d[d] = 1'b0;
    k = 1;
    seen = 1'b0;
    while (!seen && k <= 40) begin
      if (ready_o[d] === 1'b1) begin
        seen = 1'b1;
      end else begin
        chk("busy_wait", busy_o[d], 1);
        @(negedge clk);
        k++;
      end
    end
    e = exp_q.pop_front();
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: dut %0d no mem_ready within 40 cycles", d);
    end else begin
      chk("latency", k, ws_of[d] + 1);
      chk("busy_done", busy_o[d], 1);
      chk("rdata", rdata_o[d], e);
`ifdef MEM_RESP_PARITY_EN
      chk("parity_err", perr_o[d], exp_perr);
`endif
      if (!w) held[d] = e;
      @(negedge clk);
      chk("ready_pulse", ready_o[d], 0);
      chk("busy_idle", busy_o[d], 0);
      chk("req_err_quiet", rerr_o[d], 0);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      a[d] = '0; wdat[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0; inj_d[d] = 1'b0; held[d] = '0;
    end
    tbl[0] = '{1, 1'b1, 8'h10, 8'hA5, 8'h00};
    tbl[1] = '{1, 1'b0, 8'h10, 8'h00, 8'hA5};
    tbl[2] = '{1, 1'b1, 8'h11, 8'h5A, 8'hA5};
    tbl[3] = '{1, 1'b0, 8'h11, 8'h00, 8'h5A};
    tbl[4] = '{2, 1'b1, 8'h45, 8'hC3, 8'h00};
    tbl[5] = '{2, 1'b0, 8'h05, 8'h00, 8'hC3};
    tbl[6] = '{2, 1'b1, 8'h3F, 8'h81, 8'hC3};
    tbl[7] = '{2, 1'b0, 8'hBF, 8'h00, 8'h81};

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_rdata", rdata_o[d], 0);
      chk("rst_ready", ready_o[d], 0);
      chk("rst_busy", busy_o[d], 0);
      chk("rst_req_err", rerr_o[d], 0);
      chk("rst_state", state_o[d], S_IDLE);
    end
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      access(tbl[i].d, tbl[i].w, tbl[i].addr, tbl[i].wdata, 1'b0, tbl[i].exp_rd, 1'b0);

    // Both request lines high: error pulse only, RAM untouched.
    a[1] = 8'h10; wdat[1] = 8'hFF; rd[1] = 1'b1; wr[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("req_err_pulse", rerr_o[1], 1);
    chk("req_err_busy", busy_o[1], 0);
    chk("req_err_ready", ready_o[1], 0);
    rd[1] = 1'b0; wr[1] = 1'b0;
    @(negedge clk);
    chk("req_err_clear", rerr_o[1], 0);
    chk("req_err_state", state_o[1], S_IDLE);
    access(1, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5, 1'b0);

    // Zero wait states: full sweep of writes then reads.
    for (int i = 0; i < 256; i++)
      access(0, 1'b1, 8'(i), 8'(i) ^ 8'h5A, 1'b0, held[0], 1'b0);
    for (int i = 0; i < 256; i++)
      access(0, 1'b0, 8'(i), 8'h00, 1'b0, 8'(i) ^ 8'h5A, 1'b0);

    // Read held high across DONE is re-accepted two cycles later.
    a[0] = 8'h03; rd[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("held_ready1", ready_o[0], 1);
    chk("held_rdata1", rdata_o[0], 8'h59);
    @(negedge clk);
    chk("held_gap_ready", ready_o[0], 0);
    chk("held_gap_busy", busy_o[0], 0);
    @(negedge clk);
    chk("held_ready2", ready_o[0], 1);
    chk("held_busy2", busy_o[0], 1);
    rd[0] = 1'b0;
    @(negedge clk);
    chk("held_end_ready", ready_o[0], 0);
    chk("held_end_busy", busy_o[0], 0);
    held[0] = 8'h59;

    // Reset during WAIT of a write: write dropped, outputs cleared.
    access(2, 1'b1, 8'h20, 8'h11, 1'b0, held[2], 1'b0);
    a[2] = 8'h20; wdat[2] = 8'h3C; wr[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy1", busy_o[2], 1);
    wr[2] = 1'b0;
    @(negedge clk);
    chk("abort_state", state_o[2], S_WAIT);
    chk("abort_ready", ready_o[2], 0);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("abort_rdata", rdata_o[d], 0);
      chk("abort_busy", busy_o[d], 0);
      chk("abort_readyz", ready_o[d], 0);
      chk("abort_state_idle", state_o[d], S_IDLE);
      held[d] = '0;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(2, 1'b0, 8'h20, 8'h00, 1'b0, 8'h11, 1'b0);
    access(1, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5, 1'b0);

`ifdef MEM_RESP_PARITY_EN
    access(1, 1'b1, 8'h30, 8'h07, 1'b1, held[1], 1'b0);
    access(1, 1'b0, 8'h30, 8'h00, 1'b0, 8'h07, 1'b1);
    access(1, 1'b1, 8'h31, 8'h07, 1'b0, held[1], 1'b0);
    access(1, 1'b0, 8'h31, 8'h00, 1'b0, 8'h07, 1'b0);
`endif

    // A few random-address reads on the 64-word instance against known contents.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ra;
      ra = 8'($urandom_range(0, 3)) << 6;
      access(2, 1'b0, ra | 8'h20, 8'h00, 1'b0, 8'h11, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
